// File: rtl/count_timer_ctrl_if.sv
// Handshake bundle between the count/timer sequencer and the BCD counter / display path.
// type_sel carries the count direction request (0 = up, 1 = down).
interface count_timer_ctrl_if;
    logic       btn_start;
    logic       btn_load;
    logic       type_sel;
    logic [7:0] q;
    logic       cnt_en;
    logic       cnt_load;
    logic       cnt_dir;
    logic [2:0] state;
    logic       alarm;
    logic       blank;

    modport master (
        output btn_start, btn_load, type_sel, q,
        input  cnt_en, cnt_load, cnt_dir, state, alarm, blank
    );

    modport slave (
        input  btn_start, btn_load, type_sel, q,
        output cnt_en, cnt_load, cnt_dir, state, alarm, blank
    );
endinterface

// File: rtl/count_timer_ctrl.sv
// Sequencer for the 2-digit BCD counter: tick prescaler, start/pause/load buttons,
// direction latching, terminal-count detection and end-of-count alarm with blink.
module count_timer_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ALARM_TICKS = 5
) (
    input logic               clk,
    input logic               clr,
    count_timer_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_TICKS - 1);

    logic [2:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_acnt;
    logic          r_start_d;
    logic          r_load_d;
    logic          r_en;
    logic          r_load;
    logic          r_dir;
    logic          r_alarm;
    logic          r_blank;

    logic          w_load_e;
    logic          w_start_e;
    logic          w_tick;
    logic          w_term_run;
    logic          w_term_req;
    logic [PW-1:0] w_presc_inc;
    logic [2:0]    w_nxt_state;
    logic [PW-1:0] w_nxt_presc;
    logic [AW-1:0] w_nxt_acnt;
    logic          w_nxt_en;
    logic          w_nxt_load;
    logic          w_nxt_dir;

    // Load beats start when both buttons rise together.
    assign w_load_e    = bus.btn_load & ~r_load_d;
    assign w_start_e   = bus.btn_start & ~r_start_d & ~w_load_e;
    assign w_tick      = (r_presc == P_LAST);
    assign w_presc_inc = w_tick ? '0 : r_presc + 1'b1;
    assign w_term_run  = (bus.q == (r_dir ? 8'h00 : 8'h99));
    assign w_term_req  = (bus.q == (bus.type_sel ? 8'h00 : 8'h99));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_presc = r_presc;
        w_nxt_acnt  = r_acnt;
        w_nxt_en    = 1'b0;
        w_nxt_load  = 1'b0;
        w_nxt_dir   = r_dir;
        case (r_state)
            S_IDLE: begin
                w_nxt_presc = '0;
                if (w_load_e) begin
                    w_nxt_load = 1'b1;
                end else if (w_start_e && !w_term_req) begin
                    w_nxt_state = S_RUN;
                    w_nxt_dir   = bus.type_sel;
                end
            end
            S_RUN: begin
                w_nxt_presc = w_presc_inc;
                if (w_load_e) begin
                    w_nxt_load  = 1'b1;
                    w_nxt_state = S_IDLE;
                end else if (w_start_e) begin
                    w_nxt_state = S_PAUSE;
                end else if (w_term_run) begin
                    w_nxt_state = S_DONE;
                    w_nxt_presc = '0;
                end else if (w_tick) begin
                    w_nxt_en = 1'b1;
                end
            end
            S_PAUSE: begin
                // Prescaler frozen here so a resume continues the interrupted period.
                if (w_load_e) begin
                    w_nxt_load  = 1'b1;
                    w_nxt_state = S_IDLE;
                end else if (w_start_e) begin
                    w_nxt_state = S_RUN;
                end
            end
            S_DONE: begin
                w_nxt_presc = w_presc_inc;
                if (w_load_e) begin
                    w_nxt_load  = 1'b1;
                    w_nxt_state = S_IDLE;
                end else if (w_start_e) begin
                    w_nxt_state = S_IDLE;
                end else if (w_tick) begin
                    if (r_acnt == A_LAST) begin
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_acnt = r_acnt + 1'b1;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_presc = '0;
            end
        endcase
        if (w_nxt_state != S_DONE) begin
            w_nxt_acnt = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_acnt    <= '0;
            r_start_d <= 1'b1;
            r_load_d  <= 1'b1;
            r_en      <= 1'b0;
            r_load    <= 1'b0;
            r_dir     <= 1'b0;
            r_alarm   <= 1'b0;
            r_blank   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_presc   <= w_nxt_presc;
            r_acnt    <= w_nxt_acnt;
            r_start_d <= bus.btn_start;
            r_load_d  <= bus.btn_load;
            r_en      <= w_nxt_en;
            r_load    <= w_nxt_load;
            r_dir     <= w_nxt_dir;
            r_alarm   <= (w_nxt_state == S_DONE);
            // Blank follows the prescaler phase that will be current alongside DONE.
            r_blank   <= (w_nxt_state == S_DONE) && (w_nxt_presc >= P_HALF);
        end
    end

    assign bus.cnt_en   = r_en;
    assign bus.cnt_load = r_load;
    assign bus.cnt_dir  = r_dir;
    assign bus.state    = r_state;
    assign bus.alarm    = r_alarm;
    assign bus.blank    = r_blank;
endmodule

// File: tb/tb_count_timer_ctrl.sv
// Directed bench for count_timer_ctrl with TICK_DIV=4, ALARM_TICKS=2 and a behavioural BCD counter.
module tb_count_timer_ctrl;
    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   n_en;
    int   n_load;
    int   n_overlap;
    int   n_steps;
    int   step_base;
    int   cyc;
    logic [7:0] q_init;

    count_timer_ctrl_if ifc ();

    count_timer_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_walk(input logic [7:0] s, input logic dn, input int n);
        logic [3:0] t;
        logic [3:0] o;
        t = s[7:4];
        o = s[3:0];
        for (int i = 0; i < n; i++) begin
            if (dn) begin
                if (o == 4'd0) begin
                    o = 4'd9;
                    t = (t == 4'd0) ? 4'd9 : t - 4'd1;
                end else begin
                    o = o - 4'd1;
                end
            end else begin
                if (o == 4'd9) begin
                    o = 4'd0;
                    t = (t == 4'd9) ? 4'd0 : t + 4'd1;
                end else begin
                    o = o + 4'd1;
                end
            end
        end
        return {t, o};
    endfunction

    // Counter model: steps on the edge that samples cnt_en high.
    assign ifc.q = bcd_walk(q_init, ifc.cnt_dir, n_steps - step_base);

    always @(negedge clk) begin
        if (ifc.cnt_load) n_load = n_load + 1;
        if (ifc.cnt_en && ifc.cnt_load) n_overlap = n_overlap + 1;
        if (ifc.cnt_en) begin
            n_en = n_en + 1;
            @(posedge clk);
            #1;
            n_steps = n_steps + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_q(input logic [7:0] v);
        q_init    = v;
        step_base = n_steps;
    endtask

    initial begin
        checks = 0; failures = 0; n_en = 0; n_load = 0; n_overlap = 0;
        n_steps = 0; step_base = 0; cyc = 0; q_init = 8'h00;
        clr = 1'b0;
        ifc.btn_start = 1'b1;
        ifc.btn_load  = 1'b0;
        ifc.type_sel  = 1'b0;

        // Reset with start held high: no edge after release.
        step(2);
        chk("rst_state", 32'(ifc.state), 32'd0);
        chk("rst_outs", 32'({ifc.cnt_en, ifc.cnt_load, ifc.cnt_dir, ifc.alarm, ifc.blank}), 32'd0);
        clr = 1'b1;
        step(3);
        chk("held_start_state", 32'(ifc.state), 32'd0);
        ifc.btn_start = 1'b0;
        step(1);

        // Down count 03 -> 00, then DONE.
        ifc.type_sel = 1'b1;
        set_q(8'h03);
        ifc.btn_start = 1'b1;
        step(1);
        chk("run_state", 32'(ifc.state), 32'd1);
        chk("run_dir", 32'(ifc.cnt_dir), 32'd1);
        ifc.btn_start = 1'b0;
        step(3);
        chk("pre_tick_en", 32'(ifc.cnt_en), 32'd0);
        step(1);
        chk("first_en", 32'(ifc.cnt_en), 32'd1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            cyc = cyc + 1;
            if (ifc.state == 3'd3) break;
        end
        chk("done_latency", 32'(cyc), 32'd10);
        chk("done_state", 32'(ifc.state), 32'd3);
        chk("done_en_count", 32'(n_en), 32'd3);
        chk("done_q", 32'(ifc.q), 32'h00);
        chk("done_alarm", 32'(ifc.alarm), 32'd1);
        chk("blank_p0", 32'(ifc.blank), 32'd0);

        // Blink pattern and auto-return after two ticks.
        step(1); chk("blank_p1", 32'(ifc.blank), 32'd0);
        step(1); chk("blank_p2", 32'(ifc.blank), 32'd1);
        step(1); chk("blank_p3", 32'(ifc.blank), 32'd1);
        step(1); chk("blank_wrap", 32'(ifc.blank), 32'd0);
        chk("alarm_mid", 32'(ifc.alarm), 32'd1);
        step(3); chk("done_last", 32'(ifc.state), 32'd3);
        step(1);
        chk("done_exit_state", 32'(ifc.state), 32'd0);
        chk("done_exit_alarm", 32'(ifc.alarm), 32'd0);
        chk("done_exit_blank", 32'(ifc.blank), 32'd0);

        // Pause mid-period, resume keeps prescaler phase.
        ifc.type_sel = 1'b0;
        set_q(8'h42);
        ifc.btn_start = 1'b1;
        step(1);
        chk("run2_state", 32'(ifc.state), 32'd1);
        ifc.btn_start = 1'b0;
        step(2);
        ifc.btn_start = 1'b1;
        step(1);
        chk("pause_state", 32'(ifc.state), 32'd2);
        chk("pause_no_en", 32'(ifc.cnt_en), 32'd0);
        ifc.btn_start = 1'b0;
        step(3);
        chk("pause_hold", 32'(ifc.state), 32'd2);
        chk("pause_en_count", 32'(n_en), 32'd3);
        ifc.btn_start = 1'b1;
        step(1);
        chk("resume_state", 32'(ifc.state), 32'd1);
        chk("resume_en0", 32'(ifc.cnt_en), 32'd0);
        ifc.btn_start = 1'b0;
        step(1);
        chk("resume_en1", 32'(ifc.cnt_en), 32'd1);

        // Start and load together in RUN: load wins.
        ifc.btn_start = 1'b1;
        ifc.btn_load  = 1'b1;
        step(1);
        chk("both_state", 32'(ifc.state), 32'd0);
        chk("both_load", 32'(ifc.cnt_load), 32'd1);
        chk("both_en", 32'(ifc.cnt_en), 32'd0);
        ifc.btn_start = 1'b0;
        ifc.btn_load  = 1'b0;
        step(1);
        chk("both_load_end", 32'(ifc.cnt_load), 32'd0);
        chk("both_no_pause", 32'(ifc.state), 32'd0);

        // Load in IDLE stays in IDLE.
        ifc.btn_load = 1'b1;
        step(1);
        chk("idle_load", 32'(ifc.cnt_load), 32'd1);
        chk("idle_load_state", 32'(ifc.state), 32'd0);
        ifc.btn_load = 1'b0;

        // Start at terminal is ignored.
        set_q(8'h99);
        step(1);
        ifc.btn_start = 1'b1;
        step(1);
        chk("term_ignore", 32'(ifc.state), 32'd0);
        ifc.btn_start = 1'b0;
        step(5);
        chk("term_ignore_hold", 32'(ifc.state), 32'd0);
        chk("term_en_count", 32'(n_en), 32'd4);

        // Direction change during RUN has no effect.
        set_q(8'h50);
        ifc.btn_start = 1'b1;
        step(1);
        chk("run3_state", 32'(ifc.state), 32'd1);
        ifc.btn_start = 1'b0;
        ifc.type_sel  = 1'b1;
        step(2);
        chk("dir_stable", 32'(ifc.cnt_dir), 32'd0);
        chk("run3_hold", 32'(ifc.state), 32'd1);
        step(4);
        chk("q_up_step", 32'(ifc.q), 32'h51);
        chk("load_count", 32'(n_load), 32'd2);
        chk("no_overlap", 32'(n_overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
